// File: rtl/dbus_timer.sv
// dbus_timer -- memory-mapped timer/compare responder on the CPU data bus.
//
// Decodes an 8-word window at BASE_ADDR. It services word reads with a fixed
// 1-cycle latency and byte-enabled writes. It holds a prescaled free-running
// 32-bit counter, a sticky compare-match flag and a level interrupt.
//
// Ports:
//   i_Clk         clock, rising edge
//   i_Rst_n       asynchronous active-low reset
//   i_DBusAddr    word address (30b); [29:3] selects window, [2:0] register
//   i_DBusRe      read strobe
//   i_DBusWe      write strobe
//   i_DBusByteEn  byte-lane write enables
//   i_DBusWd      write data
//   o_DBusRd      registered read data, 0 when no read is returned
//   o_Irq         STATUS.MATCH & CTRL.IRQ_EN
//
// Register map (word offset):
//   0 CTRL     {IRQ_EN, AUTO_RELOAD, EN}
//   1 PRESCALE [PRESCALE_W-1:0]
//   2 COUNT
//   3 COMPARE
//   4 STATUS   {MATCH}, write 1 to clear
//   5..7       read 0, writes ignored
module dbus_timer #(
   parameter logic [29:0] BASE_ADDR  = 30'h0400_0000,
   parameter int unsigned PRESCALE_W = 16
) (
   input  logic        i_Clk,
   input  logic        i_Rst_n,
   input  logic [29:0] i_DBusAddr,
   input  logic        i_DBusRe,
   input  logic        i_DBusWe,
   input  logic [3:0]  i_DBusByteEn,
   input  logic [31:0] i_DBusWd,
   output logic [31:0] o_DBusRd,
   output logic        o_Irq
);

   localparam logic [2:0] OFF_CTRL   = 3'd0;
   localparam logic [2:0] OFF_PRESC  = 3'd1;
   localparam logic [2:0] OFF_COUNT  = 3'd2;
   localparam logic [2:0] OFF_CMP    = 3'd3;
   localparam logic [2:0] OFF_STATUS = 3'd4;

   // Replace only the byte lanes whose enable is set.
   function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  be);
      logic [31:0] r;
      r = old_v;
      for (int n = 0; n < 4; n++)
         if (be[n]) r[8*n +: 8] = new_v[8*n +: 8];
      return r;
   endfunction

   logic [2:0]            ctrl_q,   ctrl_d;
   logic [PRESCALE_W-1:0] presc_q,  presc_d;
   logic [PRESCALE_W-1:0] pcnt_q,   pcnt_d;
   logic [31:0]           count_q,  count_d;
   logic [31:0]           cmp_q,    cmp_d;
   logic                  match_q,  match_d;
   logic [31:0]           rd_q,     rd_d;

   logic        sel;
   logic [2:0]  off;
   logic        wr_any;
   logic        wr_ctrl, wr_presc, wr_count, wr_cmp;
   logic        w1c;
   logic        tick;
   logic [31:0] cnt_inc;
   logic [31:0] presc_ext;

   assign sel       = (i_DBusAddr[29:3] == BASE_ADDR[29:3]);
   assign off       = i_DBusAddr[2:0];
   // A write with no lanes enabled touches nothing, including side effects.
   assign wr_any    = sel & i_DBusWe & (|i_DBusByteEn);
   assign wr_ctrl   = wr_any & (off == OFF_CTRL);
   assign wr_presc  = wr_any & (off == OFF_PRESC);
   assign wr_count  = wr_any & (off == OFF_COUNT);
   assign wr_cmp    = wr_any & (off == OFF_CMP);
   assign w1c       = wr_any & (off == OFF_STATUS) & i_DBusByteEn[0] & i_DBusWd[0];

   assign presc_ext = 32'(presc_q);
   assign tick      = ctrl_q[0] & (pcnt_q == presc_q);
   assign cnt_inc   = count_q + 32'd1;

   always_comb begin
      ctrl_d  = ctrl_q;
      presc_d = presc_q;
      cmp_d   = cmp_q;
      pcnt_d  = pcnt_q;
      count_d = count_q;
      match_d = match_q & ~w1c;
      rd_d    = '0;

      if (wr_ctrl && i_DBusByteEn[0]) ctrl_d = i_DBusWd[2:0];
      if (wr_presc) presc_d = PRESCALE_W'(lane_merge(presc_ext, i_DBusWd, i_DBusByteEn));
      if (wr_cmp)   cmp_d   = lane_merge(cmp_q, i_DBusWd, i_DBusByteEn);

      if (ctrl_q[0]) pcnt_d = tick ? '0 : pcnt_q + 1'b1;
      // Reprogramming the prescaler or the count restarts the tick phase.
      if (wr_presc || wr_count) pcnt_d = '0;

      // A bus write to COUNT overrides the tick entirely, including its match.
      if (wr_count) begin
         count_d = lane_merge(count_q, i_DBusWd, i_DBusByteEn);
      end else if (tick) begin
         if (cnt_inc == cmp_q) begin
            match_d = 1'b1;               // set beats a same-cycle clear
            count_d = ctrl_q[1] ? '0 : cnt_inc;
         end else begin
            count_d = cnt_inc;
         end
      end

      // Read data reflects state before this cycle's updates.
      if (sel && i_DBusRe) begin
         case (off)
            OFF_CTRL:   rd_d = {29'b0, ctrl_q};
            OFF_PRESC:  rd_d = presc_ext;
            OFF_COUNT:  rd_d = count_q;
            OFF_CMP:    rd_d = cmp_q;
            OFF_STATUS: rd_d = {31'b0, match_q};
            default:    rd_d = '0;
         endcase
      end
   end

   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         ctrl_q  <= '0;
         presc_q <= '0;
         pcnt_q  <= '0;
         count_q <= '0;
         cmp_q   <= '0;
         match_q <= 1'b0;
         rd_q    <= '0;
      end else begin
         ctrl_q  <= ctrl_d;
         presc_q <= presc_d;
         pcnt_q  <= pcnt_d;
         count_q <= count_d;
         cmp_q   <= cmp_d;
         match_q <= match_d;
         rd_q    <= rd_d;
      end
   end

   assign o_DBusRd = rd_q;
   assign o_Irq    = match_q & ctrl_q[2];

endmodule

// File: tb/tb_dbus_timer.sv
// Bench for dbus_timer: directed scenarios followed by random bus traffic,
// all checked against a transaction-level model of the register file.
module tb_dbus_timer;

   localparam logic [29:0] BASE = 30'h0400_0000;

   logic        i_Clk = 1'b0;
   logic        i_Rst_n = 1'b0;
   logic [29:0] i_DBusAddr = '0;
   logic        i_DBusRe = 1'b0;
   logic        i_DBusWe = 1'b0;
   logic [3:0]  i_DBusByteEn = '0;
   logic [31:0] i_DBusWd = '0;
   logic [31:0] o_DBusRd;
   logic        o_Irq;

   dbus_timer #(.BASE_ADDR(BASE), .PRESCALE_W(16)) dut (
      .i_Clk(i_Clk), .i_Rst_n(i_Rst_n), .i_DBusAddr(i_DBusAddr),
      .i_DBusRe(i_DBusRe), .i_DBusWe(i_DBusWe), .i_DBusByteEn(i_DBusByteEn),
      .i_DBusWd(i_DBusWd), .o_DBusRd(o_DBusRd), .o_Irq(o_Irq)
   );

   always #5 i_Clk = ~i_Clk;

   int n_chk = 0;
   int n_pass = 0;

   // Reference model state
   logic [2:0]  m_ctrl;
   logic [15:0] m_pre, m_pcnt;
   logic [31:0] m_cnt, m_cmp, m_rd;
   logic        m_match;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, got, exp);
   endtask

   task automatic model_reset();
      m_ctrl = '0; m_pre = '0; m_pcnt = '0; m_cnt = '0; m_cmp = '0;
      m_match = 1'b0; m_rd = '0;
   endtask

   function automatic logic [31:0] lanes(input logic [3:0] be);
      return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
   endfunction

   // One bus cycle applied to the model: returns pre-update read data and
   // advances the timer by one clock.
   task automatic model_cycle(input logic re, input logic we, input logic [29:0] addr,
                              input logic [3:0] be, input logic [31:0] wd);
      logic        s, wen, tick;
      logic [2:0]  o;
      logic [31:0] mk, rv, nxt;
      s   = (addr[29:3] == BASE[29:3]);
      o   = addr[2:0];
      wen = s && we && (be != 4'b0);
      mk  = lanes(be);
      case (o)
         3'd0: rv = {29'b0, m_ctrl};
         3'd1: rv = {16'b0, m_pre};
         3'd2: rv = m_cnt;
         3'd3: rv = m_cmp;
         3'd4: rv = {31'b0, m_match};
         default: rv = 32'b0;
      endcase
      m_rd = (s && re) ? rv : 32'b0;

      tick = m_ctrl[0] && (m_pcnt == m_pre);
      if (wen && o == 3'd4 && be[0] && wd[0]) m_match = 1'b0;
      if (m_ctrl[0]) m_pcnt = tick ? 16'd0 : m_pcnt + 16'd1;
      if (wen && (o == 3'd1 || o == 3'd2)) m_pcnt = 16'd0;
      if (wen && o == 3'd2) begin
         m_cnt = (m_cnt & ~mk) | (wd & mk);
      end else if (tick) begin
         nxt = m_cnt + 32'd1;
         if (nxt == m_cmp) begin
            m_match = 1'b1;
            m_cnt = m_ctrl[1] ? 32'd0 : nxt;
         end else begin
            m_cnt = nxt;
         end
      end
      if (wen && o == 3'd3) m_cmp = (m_cmp & ~mk) | (wd & mk);
      if (wen && o == 3'd1) begin
         nxt = ({16'b0, m_pre} & ~mk) | (wd & mk);
         m_pre = nxt[15:0];
      end
      if (wen && o == 3'd0 && be[0]) m_ctrl = wd[2:0];
   endtask

   task automatic step(input logic re, input logic we, input logic [29:0] addr,
                       input logic [3:0] be, input logic [31:0] wd);
      @(negedge i_Clk);
      i_DBusRe = re; i_DBusWe = we; i_DBusAddr = addr; i_DBusByteEn = be; i_DBusWd = wd;
      @(posedge i_Clk);
      #1;
      model_cycle(re, we, addr, be, wd);
      check("rdata", o_DBusRd, m_rd);
      check("irq", {31'b0, o_Irq}, {31'b0, m_match & m_ctrl[2]});
   endtask

   task automatic wr(input logic [2:0] o, input logic [3:0] be, input logic [31:0] wd);
      step(1'b0, 1'b1, BASE + 30'(o), be, wd);
   endtask

   task automatic rdr(input logic [2:0] o);
      step(1'b1, 1'b0, BASE + 30'(o), 4'b0, 32'b0);
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 30'b0, 4'b0, 32'b0);
   endtask

   initial begin
      logic [29:0] a;
      logic [31:0] wd;
      model_reset();
      #2;
      check("rst_rd", o_DBusRd, 32'b0);
      check("rst_irq", {31'b0, o_Irq}, 32'b0);
      @(negedge i_Clk);
      @(negedge i_Clk);
      i_Rst_n = 1'b1;

      // Reset values of every offset, plus an out-of-window read
      for (int k = 0; k < 8; k++) begin
         rdr(3'(k));
         check("rst_reg", o_DBusRd, 32'b0);
      end
      step(1'b1, 1'b0, BASE + 30'd8, 4'b0, 32'b0);
      check("outside", o_DBusRd, 32'b0);

      // Auto-reload match every 5 ticks with prescale 0
      wr(3'd3, 4'hF, 32'd5);
      wr(3'd1, 4'hF, 32'd0);
      wr(3'd0, 4'h1, 32'h7);
      for (int k = 1; k <= 5; k++) begin
         idle();
         check("irq_at5", {31'b0, o_Irq}, (k == 5) ? 32'd1 : 32'd0);
      end
      rdr(3'd2);
      check("cnt_reload", o_DBusRd, 32'd0);
      for (int k = 0; k < 12; k++) rdr(3'd2);

      // Prescale 3, no reload, no irq
      wr(3'd0, 4'h1, 32'h0);
      wr(3'd4, 4'h1, 32'h1);
      wr(3'd2, 4'hF, 32'd0);
      wr(3'd1, 4'hF, 32'd3);
      wr(3'd3, 4'hF, 32'd2);
      wr(3'd0, 4'h1, 32'h1);
      for (int k = 0; k < 20; k++) rdr((k % 2 == 0) ? 3'd2 : 3'd4);

      // Single-lane COUNT write coinciding with a tick
      wr(3'd0, 4'h1, 32'h0);
      wr(3'd2, 4'hF, 32'h1122_3344);
      wr(3'd1, 4'hF, 32'd0);
      wr(3'd0, 4'h1, 32'h1);
      wr(3'd2, 4'b0010, 32'hAABB_CCDD);
      rdr(3'd2);
      check("cnt_lane1", o_DBusRd, 32'h1122_CC44);

      // Match set wins over a same-cycle W1C
      wr(3'd0, 4'h1, 32'h0);
      wr(3'd4, 4'h1, 32'h1);
      wr(3'd2, 4'hF, 32'd0);
      wr(3'd1, 4'hF, 32'd0);
      wr(3'd3, 4'hF, 32'd3);
      wr(3'd0, 4'h1, 32'h7);
      for (int k = 0; k < 5; k++) idle();
      wr(3'd4, 4'h1, 32'h1);
      check("set_wins", {31'b0, o_Irq}, 32'd1);
      wr(3'd0, 4'h1, 32'h4);
      wr(3'd4, 4'h1, 32'h1);
      check("w1c_irq", {31'b0, o_Irq}, 32'd0);
      rdr(3'd4);
      check("w1c_status", o_DBusRd, 32'd0);

      // Read and write to COMPARE in the same cycle
      wr(3'd3, 4'hF, 32'h10);
      step(1'b1, 1'b1, BASE + 30'd3, 4'hF, 32'h20);
      check("rw_old", o_DBusRd, 32'h10);
      rdr(3'd3);
      check("rw_new", o_DBusRd, 32'h20);

      // Random traffic, mostly inside the window with small data values
      for (int k = 0; k < 600; k++) begin
         a  = ($urandom_range(0, 7) == 0) ? BASE + 30'd8 + 30'($urandom_range(0, 15))
                                          : BASE + 30'($urandom_range(0, 7));
         wd = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 12));
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a,
              4'($urandom_range(0, 15)), wd);
      end

      // Asynchronous reset with read data and interrupt pending
      wr(3'd0, 4'h1, 32'h0);
      wr(3'd2, 4'hF, 32'd0);
      wr(3'd1, 4'hF, 32'd0);
      wr(3'd3, 4'hF, 32'd1);
      wr(3'd0, 4'h1, 32'h7);
      idle();
      rdr(3'd3);
      check("pre_rst_rd", o_DBusRd, 32'd1);
      #2;
      i_Rst_n = 1'b0;
      #1;
      check("async_rd", o_DBusRd, 32'b0);
      check("async_irq", {31'b0, o_Irq}, 32'b0);
      model_reset();
      @(negedge i_Clk);
      i_Rst_n = 1'b1;
      for (int k = 0; k < 5; k++) rdr(3'(k));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/dbus_timer.md
Name: dbus_timer

Overview:
- Memory-mapped timer/compare peripheral; responder on the CPU data bus (DBUS). The CPU pipeline is the initiator.
- Decodes an 8-word window and services word reads and byte-enabled writes from the CPU memory stage.
- Returns read data one cycle later, aligned with the CPU write-back stage.
- Provides a free-running prescaled 32-bit counter, a compare match flag and an interrupt output.

Parameters:
- BASE_ADDR, 30'h0400_0000, word address of register 0. Bits [2:0] must be zero.
- PRESCALE_W, 16, width of the prescaler register and prescaler counter (1..32).

Ports:
- i_Clk  in  1  clock; all state updates on rising edge.
- i_Rst_n  in  1  asynchronous active-low reset.
- i_DBusAddr  in  30  word address from initiator.
- i_DBusRe  in  1  read request, single-cycle strobe.
- i_DBusWe  in  1  write request, single-cycle strobe.
- i_DBusByteEn  in  4  byte-lane write enables; bit n covers Wd[8n+7:8n].
- i_DBusWd  in  32  write data.
- o_DBusRd  out  32  registered read data; zero when not returning a selected read, so responder outputs can be OR-combined.
- o_Irq  out  1  level interrupt, equal to STATUS.MATCH & CTRL.IRQ_EN.

Behaviour:
- Select: sel = (i_DBusAddr[29:3] == BASE_ADDR[29:3]). Word offset is i_DBusAddr[2:0].
- Register map (offset):
  - 0 CTRL: bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN. Other bits read 0.
  - 1 PRESCALE: [PRESCALE_W-1:0]. Upper bits read 0.
  - 2 COUNT: 32-bit.
  - 3 COMPARE: 32-bit.
  - 4 STATUS: bit0 MATCH, sticky; write 1 to clear.
  - 5..7: read 0; writes ignored.
- Writes (sel & We):
  - Only lanes with ByteEn set update.
  - STATUS W1C uses lane 0 only: ByteEn[0] & Wd[0].
  - ByteEn = 0 is a no-op.
- Reads (sel & Re): o_DBusRd on the next edge = register value before any same-cycle update.
  - Any cycle without sel & Re drives o_DBusRd to 0 on the next edge.
  - Read latency is exactly 1 cycle. No stall or wait states.
- Simultaneous Re & We to the same register: both performed; read returns the pre-write value.
- Prescaler counter pcnt (PRESCALE_W bits):
  - When EN=1: pcnt increments each cycle. When pcnt == PRESCALE, pcnt <= 0 and tick=1.
  - PRESCALE=0 gives a tick every enabled cycle.
- On tick: nxt = COUNT + 1 (32-bit, wraps FFFF_FFFF -> 0).
  - If nxt == COMPARE: MATCH <= 1; COUNT <= AUTO_RELOAD ? 0 : nxt.
  - Else: COUNT <= nxt.
- EN=0: pcnt and COUNT hold their values; no ticks.
- Priority and side effects:
  - A write to any COUNT lane and a same-cycle tick: written value wins; pcnt <= 0; no match from that tick.
  - Any write to PRESCALE: pcnt <= 0.
  - Clearing EN holds pcnt and does not reset it.
  - MATCH set and W1C in the same cycle: set wins (MATCH stays 1).
  - A write to COMPARE takes effect for the next tick.
- o_Irq is combinational from registered MATCH and IRQ_EN. No pulse stretching.
- Reset (async assert, release synchronous to i_Clk): CTRL, PRESCALE, COUNT, COMPARE, STATUS, pcnt, o_DBusRd all 0; o_Irq = 0.
  - Reset mid-transaction discards any pending read data.
  - First request is accepted on the first edge after release.

Test Plan:
- Reset, then read each offset 0..7 -> o_DBusRd = 0 one cycle after each Re. Read at BASE_ADDR+8 -> 0 and no register change.
- Write COMPARE=5, PRESCALE=0, CTRL=0x7 -> COUNT reaches 4, then 0 with MATCH=1 and o_Irq=1 exactly 5 enabled cycles after EN. Period is 5 thereafter.
- PRESCALE=3, AUTO_RELOAD=0, COMPARE=2, CTRL=0x1 -> COUNT increments every 4 cycles. MATCH sets when COUNT becomes 2; COUNT continues to 3. o_Irq stays 0 (IRQ_EN=0).
- Write COUNT with ByteEn=4'b0010, Wd=0xAABBCCDD onto COUNT=0x11223344 -> COUNT=0x1122CC44. Same-cycle tick is ignored; pcnt=0.
- MATCH=1; write STATUS Wd=1 in the same cycle a new match occurs -> MATCH stays 1. Next W1C with no match -> MATCH=0, o_Irq=0.
- Same-cycle Re & We to COMPARE (old 0x10, new 0x20) -> o_DBusRd = 0x10 next cycle, and a subsequent read returns 0x20. Assert i_Rst_n low mid-count -> all registers and o_DBusRd go to 0 immediately.
